// File: rtl/axi_slave_mem_responder_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the memory responder.
// The bridge side imports the same package.
package axi_resp_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 bus bundle between the bridge's slave-side user port and the memory responder.
interface axi_slave_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                      awvalid;
    logic                      awready;
    logic [ID_WIDTH-1:0]       awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;

    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;

    logic                      bvalid;
    logic                      bready;
    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;

    logic                      arvalid;
    logic                      arready;
    logic [ID_WIDTH-1:0]       arid;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;

    logic                      rvalid;
    logic                      rready;
    logic [ID_WIDTH-1:0]       rid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

endinterface

// File: rtl/axi_slave_mem_responder_beat_addr_gen.sv
// Per-beat byte address for FIXED/INCR bursts, flagging unsupported bursts/sizes
// and addresses that fall outside the memory window.
module axi_beat_addr_gen
    import axi_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    input  logic [7:0]            beat_idx,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  err
);
    localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] word_full;
    logic                  burst_err;
    logic                  range_err;

    always_comb begin
        burst_err = (burst == WRAP) || (size > 3'(LANE_BITS));
        addr      = start_addr;
        if (burst == INCR) begin
            addr = start_addr + (ADDR_WIDTH'(beat_idx) << size);
        end
        word_full = (addr - BASE_ADDR) >> LANE_BITS;
        range_err = (addr < BASE_ADDR) || (word_full >= ADDR_WIDTH'(MEM_DEPTH));
        err       = burst_err || range_err;
    end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave endpoint backed by a word memory: independent single-outstanding
// write and read FSMs plus saturating completion counters.
module axi_slave_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic                      s_clk_wr,
    input  logic                      s_rst_wr_n,
    axi_slave_mem_responder_if.slave  axi,
    output logic [15:0]               wr_txn_count,
    output logic [15:0]               rd_txn_count
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(STRB_WIDTH);
    localparam int IDX_BITS   = $clog2(MEM_DEPTH);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic     ready_en;

    logic [ID_WIDTH-1:0]   w_id, r_id;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0]            w_len, w_beat, r_len, r_beat;
    logic [2:0]            w_size, r_size;
    logic [1:0]            w_burst, r_burst;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic aw_fire, w_fire, w_last_beat, b_fire;
    logic ar_fire, r_fire, r_done, rd_load;

    logic [ADDR_WIDTH-1:0] w_beat_addr, r_beat_addr, r_gen_start;
    logic [2:0]            r_gen_size;
    logic [1:0]            r_gen_burst;
    logic [7:0]            r_gen_idx;
    logic                  w_gen_err, r_gen_err;
    logic [IDX_BITS-1:0]   w_idx, r_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    axi_beat_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_wr_addr (
        .start_addr(w_addr), .size(w_size), .burst(w_burst),
        .beat_idx(w_beat), .addr(w_beat_addr), .err(w_gen_err)
    );

    // While idle the read generator looks at the AR channel so beat 0 is ready at the handshake.
    assign r_gen_start = (r_state == R_IDLE) ? axi.araddr  : r_addr;
    assign r_gen_size  = (r_state == R_IDLE) ? axi.arsize  : r_size;
    assign r_gen_burst = (r_state == R_IDLE) ? axi.arburst : r_burst;
    assign r_gen_idx   = (r_state == R_IDLE) ? 8'd0 : r_beat + 8'd1;

    axi_beat_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_rd_addr (
        .start_addr(r_gen_start), .size(r_gen_size), .burst(r_gen_burst),
        .beat_idx(r_gen_idx), .addr(r_beat_addr), .err(r_gen_err)
    );

    assign w_idx = IDX_BITS'((w_beat_addr - BASE_ADDR) >> LANE_BITS);
    assign r_idx = IDX_BITS'((r_beat_addr - BASE_ADDR) >> LANE_BITS);

    always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
        if (!s_rst_wr_n) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next      = w_state;
        aw_fire     = 1'b0;
        w_fire      = 1'b0;
        w_last_beat = 1'b0;
        b_fire      = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_fire = axi.awvalid && ready_en;
                if (aw_fire) w_next = W_DATA;
            end
            W_DATA: begin
                w_fire      = axi.wvalid;
                w_last_beat = axi.wlast || (w_beat == w_len);
                if (w_fire && w_last_beat) w_next = W_RESP;
            end
            W_RESP: begin
                b_fire = axi.bready;
                if (b_fire) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        ar_fire = 1'b0;
        r_fire  = 1'b0;
        r_done  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_fire = axi.arvalid && ready_en;
                if (ar_fire) r_next = R_DATA;
            end
            R_DATA: begin
                r_fire = axi.rready;
                r_done = r_fire && (r_beat == r_len);
                if (r_done) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
        rd_load = ar_fire || (r_fire && !r_done);
    end

    // A mismatch between wlast and the beat count poisons the whole burst's response.
    always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
        if (!s_rst_wr_n) begin
            w_id <= '0; w_addr <= '0; w_len <= '0; w_size <= '0;
            w_burst <= '0; w_beat <= '0; w_err <= 1'b0;
        end else if (aw_fire) begin
            w_id    <= axi.awid;
            w_addr  <= axi.awaddr;
            w_len   <= axi.awlen;
            w_size  <= axi.awsize;
            w_burst <= axi.awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_fire) begin
            w_beat <= w_beat + 8'd1;
            if (w_gen_err || (axi.wlast != (w_beat == w_len))) w_err <= 1'b1;
        end
    end

    always_ff @(posedge s_clk_wr) begin
        if (w_fire && !w_gen_err) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
        if (!s_rst_wr_n) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0;
            r_burst <= '0; r_beat <= '0; rdata_q <= '0; rresp_q <= OKAY;
        end else begin
            if (ar_fire) begin
                r_id    <= axi.arid;
                r_addr  <= axi.araddr;
                r_len   <= axi.arlen;
                r_size  <= axi.arsize;
                r_burst <= axi.arburst;
                r_beat  <= '0;
            end else if (r_fire && !r_done) begin
                r_beat <= r_beat + 8'd1;
            end
            if (rd_load) begin
                rdata_q <= r_gen_err ? '0 : mem[r_idx];
                rresp_q <= r_gen_err ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge s_clk_wr or negedge s_rst_wr_n) begin
        if (!s_rst_wr_n) begin
            wr_txn_count <= '0;
            rd_txn_count <= '0;
        end else begin
            if (b_fire && (wr_txn_count != 16'hFFFF)) wr_txn_count <= wr_txn_count + 16'd1;
            if (r_done && (rd_txn_count != 16'hFFFF)) rd_txn_count <= rd_txn_count + 16'd1;
        end
    end

    assign axi.awready = ready_en && (w_state == W_IDLE);
    assign axi.wready  = (w_state == W_DATA);
    assign axi.bvalid  = (w_state == W_RESP);
    assign axi.bresp   = ((w_state == W_RESP) && w_err) ? SLVERR : OKAY;
    assign axi.bid     = w_id;
    assign axi.arready = ready_en && (r_state == R_IDLE);
    assign axi.rvalid  = (r_state == R_DATA);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = (r_state == R_DATA) && (r_beat == r_len);
    assign axi.rid     = r_id;

endmodule
